// File: rtl/seg7_scan_driver.sv
// Captures a binary count, converts it to BCD by shift-add-3 and scans it onto a 4-digit active-low 7-seg display.
// Latency: DATA_W+1 busy cycles per load, digits refresh on the next scan step; loads during busy are dropped.
module seg7_scan_driver #(
    parameter int DATA_W      = 8,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] value,
    input  logic              ovf,
    input  logic              load,
    output logic              busy,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [3:0]        an
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int CW = $clog2(DATA_W);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [11:0]       bcd_q, bcd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_pend_q, ovf_pend_d;
    logic [11:0]       disp_q, disp_d;
    logic              ovf_q, ovf_d;

    logic [PW-1:0]     presc_q;
    logic [1:0]        idx_q;
    logic              scan_step;
    logic [3:0]        an_d;
    logic [6:0]        seg_d;
    logic              dp_d;

    logic [11:0]          bcd_adj;
    logic [11+DATA_W:0]   cat;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign busy = (state_q != IDLE);

    // Double-dabble step: correct each nibble before the shift so it carries as decimal.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        cat = {bcd_adj, shift_q} << 1;
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d    = value;
                    ovf_pend_d = ovf;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                bcd_d   = cat[11+DATA_W:DATA_W];
                shift_d = cat[DATA_W-1:0];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(DATA_W - 1))
                    state_d = COMMIT;
            end
            COMMIT: begin
                disp_d  = bcd_q;
                ovf_d   = ovf_pend_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
        end
    end

    assign scan_step = (presc_q == PW'(REFRESH_DIV - 1));

    // Outputs latch the digit at the current index on each step, so the first step lights digit 0.
    always_comb begin
        an_d  = 4'b0111;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        case (idx_q)
            2'd0: begin
                an_d  = 4'b1110;
                seg_d = seg7(disp_q[3:0]);
                dp_d  = ~ovf_q;
            end
            2'd1: begin
                an_d  = 4'b1101;
                if (disp_q[11:8] != 4'd0 || disp_q[7:4] != 4'd0)
                    seg_d = seg7(disp_q[7:4]);
            end
            2'd2: begin
                an_d  = 4'b1011;
                if (disp_q[11:8] != 4'd0)
                    seg_d = seg7(disp_q[11:8]);
            end
            default: begin
                an_d  = 4'b0111;
                seg_d = SEG_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            an      <= 4'hF;
            seg     <= SEG_BLANK;
            dp      <= 1'b1;
        end else if (scan_step) begin
            presc_q <= '0;
            idx_q   <= idx_q + 2'd1;
            an      <= an_d;
            seg     <= seg_d;
            dp      <= dp_d;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4, DATA_W=8; hand-computed segment patterns.
module tb_seg7_scan_driver;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SB = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] value = '0;
    logic       ovf = 1'b0;
    logic       load = 1'b0;
    logic       busy;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(.DATA_W(8), .REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .value (value),
        .ovf   (ovf),
        .load  (load),
        .busy  (busy),
        .seg   (seg),
        .dp    (dp),
        .an    (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] v, input logic o);
        @(negedge clk);
        value = v;
        ovf   = o;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Counts busy cycles at negedges; leaves the bench two scan steps after commit.
    task automatic wait_idle(input string tag, input int exp_cycles);
        int n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (exp_cycles > 0)
            check({tag, "_busy_cycles"}, n, exp_cycles);
        check({tag, "_idle"}, busy, 0);
        repeat (8) @(negedge clk);
    endtask

    task automatic expect_digit(input string tag, input logic [3:0] want_an,
                                input logic [6:0] want_seg, input logic want_dp);
        int n = 0;
        while (an !== want_an && n < 40) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_an"}, an, want_an);
        check({tag, "_seg"}, seg, want_seg);
        check({tag, "_dp"}, dp, want_dp);
    endtask

    initial begin
        // 1: reset state and first scan steps
        #12;
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_step_an", an, 4'hF);
        @(negedge clk);
        check("step1_an", an, 4'hE);
        check("step1_seg", seg, S0);
        expect_digit("t1_d1", 4'hD, SB, 1'b1);
        expect_digit("t1_d2", 4'hB, SB, 1'b1);
        expect_digit("t1_d3", 4'h7, SB, 1'b1);

        // 2: 255 -> 2 5 5
        do_load(8'd255, 1'b0);
        wait_idle("t2", 9);
        expect_digit("t2_d0", 4'hE, S5, 1'b1);
        expect_digit("t2_d1", 4'hD, S5, 1'b1);
        expect_digit("t2_d2", 4'hB, S2, 1'b1);
        expect_digit("t2_d3", 4'h7, SB, 1'b1);

        // 3: 7 with leading zeros blanked
        do_load(8'd7, 1'b0);
        wait_idle("t3", 9);
        expect_digit("t3_d0", 4'hE, S7, 1'b1);
        expect_digit("t3_d1", 4'hD, SB, 1'b1);
        expect_digit("t3_d2", 4'hB, SB, 1'b1);

        // 4: 100, then 42 while busy is dropped
        do_load(8'd100, 1'b0);
        check("t4_busy_at_2nd", busy, 1);
        value = 8'd42;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        wait_idle("t4", 0);
        expect_digit("t4_d0", 4'hE, S0, 1'b1);
        expect_digit("t4_d1", 4'hD, S0, 1'b1);
        expect_digit("t4_d2", 4'hB, S1, 1'b1);

        // 5: overflow decimal point
        do_load(8'd0, 1'b1);
        wait_idle("t5a", 9);
        expect_digit("t5_d0", 4'hE, S0, 1'b0);
        expect_digit("t5_d1", 4'hD, SB, 1'b1);
        do_load(8'd0, 1'b0);
        wait_idle("t5b", 9);
        expect_digit("t5_d0_clr", 4'hE, S0, 1'b1);

        // 6: reset mid-conversion
        do_load(8'd200, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_an", an, 4'hF);
        check("t6_rst_seg", seg, 7'h7F);
        check("t6_rst_dp", dp, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_an", an, 4'hE);
        check("t6_seg", seg, S0);
        check("t6_busy", busy, 0);
        expect_digit("t6_d1", 4'hD, SB, 1'b1);
        expect_digit("t6_d2", 4'hB, SB, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
